// File: rtl/aclk_pkg.sv
// Shared definitions for the alarm-clock time-entry block.
//   - key codes delivered by the keypad scanner
//   - entry FSM state encoding
//   - entry timeout length and digit buffer depth
//   - packed BCD time buffer type
package aclk_pkg;

    localparam logic [3:0] KEY_SET      = 4'hA;
    localparam logic [3:0] KEY_CLEAR    = 4'hB;
    localparam logic [3:0] TIMEOUT_SECS = 4'd10;
    localparam logic [2:0] MAX_DIGITS   = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ENTRY = 2'd1,
        ST_LOAD  = 2'd2
    } state_e;

    typedef struct packed {
        logic [3:0] ms_hr;
        logic [3:0] ls_hr;
        logic [3:0] ms_min;
        logic [3:0] ls_min;
    } time_buf_t;

    function automatic logic is_digit(input logic [3:0] k);
        return (k <= 4'd9);
    endfunction

endpackage

// File: rtl/aclk_time_validate.sv
// Combinational check that four BCD digits form a legal 24-hour time.
// Ports:
//   ms_hr, ls_hr, ms_min, ls_min : BCD digits of HH:MM
//   valid                        : 1 when 00:00 <= HH:MM <= 23:59
module aclk_time_validate
    import aclk_pkg::*;
(
    input  logic [3:0] ms_hr,
    input  logic [3:0] ls_hr,
    input  logic [3:0] ms_min,
    input  logic [3:0] ls_min,
    output logic       valid
);

    always_comb begin
        valid = (ms_hr <= 4'd2)
             && (ls_hr <= 4'd9)
             && ((ms_hr != 4'd2) || (ls_hr <= 4'd3))
             && (ms_min <= 4'd5)
             && (ls_min <= 4'd9);
    end

endmodule

// File: rtl/aclk_time_entry.sv
// Keypad time-entry controller for the alarm clock.
// Collects up to four BCD digits (shifting left as they arrive), validates
// them on SET and issues a one-cycle load strobe to the time counter.
// An entry left idle for TIMEOUT_SECS seconds is aborted with an error pulse.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   key_valid, key        : keypad strobe and code (0-9, A=SET, B=CLEAR)
//   one_second            : 1 Hz tick for the entry timeout
//   new_current_time_*    : BCD digit buffer, feeds the time-counter load
//   load_new_c            : one-cycle load strobe
//   entry_active          : high while an entry is in progress
//   entry_error           : one-cycle pulse on rejected SET or timeout
//   digit_count           : digits entered, saturating at 4
// All outputs come straight from flops.
module aclk_time_entry
    import aclk_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key,
    input  logic       one_second,
    output logic [3:0] new_current_time_ms_hr,
    output logic [3:0] new_current_time_ls_hr,
    output logic [3:0] new_current_time_ms_min,
    output logic [3:0] new_current_time_ls_min,
    output logic       load_new_c,
    output logic       entry_active,
    output logic       entry_error,
    output logic [2:0] digit_count
);

    state_e    state_q, state_d;
    time_buf_t buf_q, buf_d;
    logic [2:0] count_q, count_d;
    logic [3:0] timeout_q, timeout_d;
    logic       load_q, load_d;
    logic       error_q, error_d;
    logic       active_q, active_d;
    logic       time_ok;
    logic       key_accepted;

    aclk_time_validate u_validate (
        .ms_hr  (buf_q.ms_hr),
        .ls_hr  (buf_q.ls_hr),
        .ms_min (buf_q.ms_min),
        .ls_min (buf_q.ls_min),
        .valid  (time_ok)
    );

    always_comb begin
        key_accepted = key_valid
                    && (is_digit(key) || (key == KEY_SET) || (key == KEY_CLEAR));
    end

    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        count_d   = count_q;
        timeout_d = timeout_q;
        load_d    = 1'b0;
        error_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (key_valid) begin
                    if (is_digit(key)) begin
                        buf_d     = '{ms_hr: 4'd0, ls_hr: 4'd0, ms_min: 4'd0, ls_min: key};
                        count_d   = 3'd1;
                        timeout_d = '0;
                        state_d   = ST_ENTRY;
                    end else if (key == KEY_SET) begin
                        error_d = 1'b1;
                    end else if (key == KEY_CLEAR) begin
                        buf_d   = '0;
                        count_d = '0;
                    end
                end
            end

            ST_ENTRY: begin
                // An accepted key always wins over a coincident tick.
                if (key_accepted) begin
                    timeout_d = '0;
                    if (is_digit(key)) begin
                        buf_d = '{ms_hr: buf_q.ls_hr, ls_hr: buf_q.ms_min,
                                  ms_min: buf_q.ls_min, ls_min: key};
                        if (count_q < MAX_DIGITS) begin
                            count_d = count_q + 3'd1;
                        end
                    end else if ((key == KEY_SET) && (count_q == MAX_DIGITS) && time_ok) begin
                        load_d  = 1'b1;
                        state_d = ST_LOAD;
                    end else begin
                        // Rejected SET reports an error; CLEAR aborts silently.
                        error_d = (key == KEY_SET);
                        buf_d   = '0;
                        count_d = '0;
                        state_d = ST_IDLE;
                    end
                end else if (one_second) begin
                    // The tenth tick aborts directly so the counter never
                    // has to hold the terminal value.
                    if (timeout_q == TIMEOUT_SECS - 4'd1) begin
                        error_d   = 1'b1;
                        buf_d     = '0;
                        count_d   = '0;
                        timeout_d = '0;
                        state_d   = ST_IDLE;
                    end else begin
                        timeout_d = timeout_q + 4'd1;
                    end
                end
            end

            ST_LOAD: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        active_d = (state_d == ST_ENTRY);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            buf_q     <= '0;
            count_q   <= '0;
            timeout_q <= '0;
            load_q    <= 1'b0;
            error_q   <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            count_q   <= count_d;
            timeout_q <= timeout_d;
            load_q    <= load_d;
            error_q   <= error_d;
            active_q  <= active_d;
        end
    end

    assign new_current_time_ms_hr  = buf_q.ms_hr;
    assign new_current_time_ls_hr  = buf_q.ls_hr;
    assign new_current_time_ms_min = buf_q.ms_min;
    assign new_current_time_ls_min = buf_q.ls_min;
    assign load_new_c              = load_q;
    assign entry_error             = error_q;
    assign entry_active            = active_q;
    assign digit_count             = count_q;

endmodule

// File: doc/aclk_time_entry.md
ACLK_TIME_ENTRY -- requirements
Module: aclk_time_entry

Interface
REQ-001 Reset shall be signal reset, asynchronous, active-high; clock shall be clk.
REQ-002 clk  input  1  system clock, all state on rising edge.
REQ-003 reset  input  1  asynchronous active-high reset.
REQ-004 key_valid  input  1  single-cycle strobe qualifying key.
REQ-005 key  input  4  key code: 0-9 digit, 4'hA SET, 4'hB CLEAR, 4'hC-4'hF ignored.
REQ-006 one_second  input  1  single-cycle 1 Hz tick for entry timeout.
REQ-007 new_current_time_ms_hr / new_current_time_ls_hr / new_current_time_ms_min / new_current_time_ls_min  output  4 each  BCD digit buffer, feeds time-counter load inputs.
REQ-008 load_new_c  output  1  single-cycle load strobe to time counter.
REQ-009 entry_active  output  1  high while FSM in ENTRY.
REQ-010 entry_error  output  1  single-cycle pulse on rejected SET or timeout abort.
REQ-011 digit_count  output  3  digits entered, 0..4, saturating.

Function
REQ-012 FSM shall have states IDLE, ENTRY, LOAD; all outputs registered.
REQ-013 IDLE + digit key: buffer cleared, digit shifted into ls_min, digit_count=1, go ENTRY, next cycle.
REQ-014 Digit shift shall be ms_hr<=ls_hr, ls_hr<=ms_min, ms_min<=ls_min, ls_min<=key.
REQ-015 ENTRY + digit key: shift; digit_count increments, saturates at 4 (oldest digit discarded beyond 4).
REQ-016 ENTRY + SET with digit_count==4 and valid time: go LOAD; load_new_c high exactly the cycle after the SET strobe, buffer unchanged.
REQ-017 Valid time: ms_hr<=2; ls_hr<=9, and ls_hr<=3 when ms_hr==2; ms_min<=5; ls_min<=9.
REQ-018 ENTRY + SET with digit_count<4 or invalid time: entry_error pulse next cycle, buffer and digit_count cleared to 0, go IDLE, no load_new_c.
REQ-019 IDLE + SET: entry_error pulse, remain IDLE.
REQ-020 CLEAR in any state except LOAD: buffer and digit_count cleared, go IDLE, no pulses.
REQ-021 LOAD lasts one cycle then IDLE; key_valid during LOAD ignored; buffer holds loaded value until next entry.
REQ-022 Key codes 4'hC-4'hF: no state change, do not restart timeout.
REQ-023 Timeout counter (4 bits) cleared on entering ENTRY and on every accepted key (0-9, A, B); increments per one_second in ENTRY.
REQ-024 When counter reaches 10 in ENTRY: entry_error pulse, buffer and digit_count cleared, go IDLE.
REQ-025 key_valid and one_second same cycle: key processed, counter cleared, tick discarded.
REQ-026 load_new_c and entry_error shall never be high in the same cycle.
REQ-027 entry_active shall equal (state==ENTRY) from register outputs, no combinational path from inputs to any output.

Reset
REQ-028 On reset: state IDLE, all four digit outputs 4'd0, load_new_c 0, entry_error 0, entry_active 0, digit_count 0, timeout counter 0.
REQ-029 Reset asserted mid-entry or during LOAD shall abort without any load_new_c or entry_error pulse.

Structure
REQ-030 Package aclk_pkg shall hold key codes (KEY_SET=4'hA, KEY_CLEAR=4'hB), FSM state encoding, TIMEOUT_SECS=10, MAX_DIGITS=4.
REQ-031 Time validity check shall be one combinational sub-module aclk_time_validate (four BCD digits in, valid out).

Verification
REQ-032 Keys 1,2,3,4,SET -> digits 1/2/3/4, load_new_c one pulse the cycle after SET, entry_error 0.
REQ-033 Keys 2,4,0,0,SET -> entry_error one pulse, digits 0/0/0/0, no load_new_c; same for 1,2,6,0.
REQ-034 Keys 9,1,2,3,5,9,SET -> buffer 2/3/5/9, digit_count 4, load_new_c pulse.
REQ-035 Keys 1,2 then 10 one_second ticks, no keys -> entry_error on 10th tick+1 cycle, IDLE, digits 0; with key 3 at tick 9 timeout restarts.
REQ-036 Keys 0,8,CLEAR,SET -> no load_new_c, entry_error pulse from IDLE SET; reset during LOAD -> load_new_c low, all outputs 0.
